// File: rtl/regfile_scoreboard_n_pkg.sv
// Shared defaults and packed-bus helpers for the scoreboarded register file.
package regfile_scoreboard_n_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned NFWD_DEF  = 2;
  localparam int unsigned CNT_W_DEF = 2;

  // Register address width for a power-of-two register count.
  function automatic int unsigned addr_w(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // LSB position of lane idx in a packed bus of w-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_n_resolver.sv
// Single read-port operand resolver: array, youngest forwarding source, or write-back.
module regfile_operand_resolver
  import regfile_scoreboard_n_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5,
  parameter int unsigned NFWD = NFWD_DEF
) (
  input  logic                 en_i,
  input  logic [AW-1:0]        rs_i,
  input  logic                 cnt_zero_i,
  input  logic [XLEN-1:0]      arr_data_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_ready_i,
  input  logic [NFWD*AW-1:0]   fwd_rd_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 wb_we_i,
  input  logic [AW-1:0]        wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 ready_o
);

  logic hit;

  // Priority resolution; the first matching forwarding source ends the scan even when not ready.
  always_comb begin
    data_o  = '0;
    ready_o = 1'b0;
    hit     = 1'b0;
    if (!en_i || rs_i == '0) begin
      ready_o = 1'b1;
    end else if (cnt_zero_i) begin
      data_o  = arr_data_i;
      ready_o = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NFWD; k++) begin
        if (!hit && fwd_valid_i[k] && fwd_rd_i[lane_lsb(k, AW) +: AW] == rs_i) begin
          hit = 1'b1;
          if (fwd_ready_i[k]) begin
            data_o  = fwd_data_i[lane_lsb(k, XLEN) +: XLEN];
            ready_o = 1'b1;
          end
        end
      end
      if (!hit && wb_we_i && wb_rd_i == rs_i) begin
        data_o  = wb_data_i;
        ready_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard_n.sv
// Register file with per-register pending-write counters, N read ports and ordered forwarding.
module regfile_scoreboard_n
  import regfile_scoreboard_n_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned NFWD  = NFWD_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned AW   = addr_w(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iss_valid_i,
  input  logic                 iss_we_i,
  input  logic [AW-1:0]        iss_rd_i,
  input  logic [NRD-1:0]       iss_rs_en_i,
  input  logic [NRD*AW-1:0]    iss_rs_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_ready_i,
  input  logic [NFWD*AW-1:0]   fwd_rd_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 wb_we_i,
  input  logic [AW-1:0]        wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic [NRD*XLEN-1:0]  rs_data_o,
  output logic [NRD-1:0]       rs_ready_o,
  output logic                 stall_o,
  output logic                 err_o
);

  logic [XLEN-1:0]  mem_q [NREG];
  logic [CNT_W-1:0] cnt_q [NREG];
  logic             err_q;

  logic [NRD*XLEN-1:0] data_w;
  logic [NRD-1:0]      ready_w;
  logic [NREG-1:0]     inc_v;
  logic [NREG-1:0]     dec_v;
  logic [NREG-1:0]     zero_v;
  logic                sat_stall;
  logic                iss_accept;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] rs_lane;
    assign rs_lane = iss_rs_i[lane_lsb(i, AW) +: AW];

    regfile_operand_resolver #(
      .XLEN (XLEN),
      .AW   (AW),
      .NFWD (NFWD)
    ) u_res (
      .en_i        (iss_rs_en_i[i]),
      .rs_i        (rs_lane),
      .cnt_zero_i  (zero_v[rs_lane]),
      .arr_data_i  (mem_q[rs_lane]),
      .fwd_valid_i (fwd_valid_i),
      .fwd_ready_i (fwd_ready_i),
      .fwd_rd_i    (fwd_rd_i),
      .fwd_data_i  (fwd_data_i),
      .wb_we_i     (wb_we_i),
      .wb_rd_i     (wb_rd_i),
      .wb_data_i   (wb_data_i),
      .data_o      (data_w[lane_lsb(i, XLEN) +: XLEN]),
      .ready_o     (ready_w[i])
    );
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    sat_stall  = iss_valid_i && iss_we_i && iss_rd_i != '0 && cnt_q[iss_rd_i] == '1;
    rs_data_o  = rst_i ? data_w  : '0;
    rs_ready_o = rst_i ? ready_w : '0;
    stall_o    = rst_i && ((~ready_w != '0) || sat_stall);
    iss_accept = iss_valid_i && !stall_o && !stall_i && !flush_i;
    err_o      = err_q;
  end

  // Per-register increment/decrement requests; register 0 never tracks writers.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      zero_v[r] = (cnt_q[r] == '0);
    end
    if (iss_accept && iss_we_i) inc_v[iss_rd_i] = 1'b1;
    if (wb_we_i)                dec_v[wb_rd_i]  = 1'b1;
    inc_v[0] = 1'b0;
    dec_v[0] = 1'b0;
  end

  // Scoreboard counters and sticky underflow flag; a flush absorbs the concurrent write-back.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (flush_i)                                   cnt_q[r] <= '0;
        else if (inc_v[r] && !dec_v[r])                cnt_q[r] <= cnt_q[r] + 1'b1;
        else if (dec_v[r] && !inc_v[r] && !zero_v[r])  cnt_q[r] <= cnt_q[r] - 1'b1;
      end
      if (!flush_i && (dec_v & ~inc_v & zero_v) != '0) err_q <= 1'b1;
    end
  end

  // Architectural array write from write-back, regardless of stall or flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else if (wb_we_i && wb_rd_i != '0) begin
      mem_q[wb_rd_i] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard_n.sv
// Self-checking bench for regfile_scoreboard_n against a behavioural register/counter model.
module tb_regfile_scoreboard_n;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NFWD = 2;
  localparam int unsigned AW   = 5;
  localparam int          CMAX = 3;

  logic                 clk, rst;
  logic                 iss_valid, iss_we;
  logic [AW-1:0]        iss_rd;
  logic [NRD-1:0]       iss_rs_en;
  logic [NRD*AW-1:0]    iss_rs;
  logic                 stall_in, flush;
  logic [NFWD-1:0]      fwd_valid, fwd_ready;
  logic [NFWD*AW-1:0]   fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 wb_we;
  logic [AW-1:0]        wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [NRD*XLEN-1:0]  rs_data;
  logic [NRD-1:0]       rs_ready;
  logic                 stall_out, err;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_mem [32];
  int              m_cnt [32];
  bit              m_err;

  regfile_scoreboard_n #(
    .XLEN(XLEN), .NREG(32), .NRD(NRD), .NFWD(NFWD), .CNT_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .iss_valid_i(iss_valid), .iss_we_i(iss_we), .iss_rd_i(iss_rd),
    .iss_rs_en_i(iss_rs_en), .iss_rs_i(iss_rs),
    .stall_i(stall_in), .flush_i(flush),
    .fwd_valid_i(fwd_valid), .fwd_ready_i(fwd_ready), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .rs_data_o(rs_data), .rs_ready_o(rs_ready), .stall_o(stall_out), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    iss_valid = 0; iss_we = 0; iss_rd = '0; iss_rs_en = '0; iss_rs = '0;
    stall_in = 0; flush = 0; fwd_valid = '0; fwd_ready = '0; fwd_rd = '0; fwd_data = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_cnt[r] = 0; end
    m_err = 0;
  endtask

  // Reference operand lookup from the resolution rules, using current inputs and model state.
  function automatic void model_port(input int p, output logic [XLEN-1:0] d, output logic r);
    int rs;
    rs = int'(iss_rs[p*AW +: AW]);
    d = '0; r = 1'b0;
    if (!rst) return;
    if (!iss_rs_en[p] || rs == 0) begin r = 1'b1; return; end
    if (m_cnt[rs] == 0) begin d = m_mem[rs]; r = 1'b1; return; end
    for (int k = 0; k < NFWD; k++) begin
      if (fwd_valid[k] && int'(fwd_rd[k*AW +: AW]) == rs) begin
        if (fwd_ready[k]) begin d = fwd_data[k*XLEN +: XLEN]; r = 1'b1; end
        return;
      end
    end
    if (wb_we && int'(wb_rd) == rs) begin d = wb_data; r = 1'b1; end
  endfunction

  function automatic bit model_stall();
    logic [XLEN-1:0] d;
    logic r;
    if (!rst) return 0;
    for (int p = 0; p < NRD; p++) begin
      model_port(p, d, r);
      if (!r) return 1;
    end
    return iss_valid && iss_we && iss_rd != 0 && m_cnt[iss_rd] == CMAX;
  endfunction

  // Advance one clock and update the model with the inputs that were presented.
  task automatic tick();
    bit acc, inc, dec;
    acc = iss_valid && !model_stall() && !stall_in && !flush;
    inc = acc && iss_we && iss_rd != 0;
    dec = wb_we && wb_rd != 0;
    @(posedge clk);
    if (rst) begin
      if (dec) m_mem[wb_rd] = wb_data;
      if (flush) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else if (!(inc && dec && iss_rd == wb_rd)) begin
        if (inc) m_cnt[iss_rd]++;
        if (dec) begin
          if (m_cnt[wb_rd] == 0) m_err = 1;
          else m_cnt[wb_rd]--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input int rd);
    idle(); iss_valid = 1; iss_we = 1; iss_rd = AW'(rd); tick();
  endtask

  task automatic writeback(input int rd, input logic [XLEN-1:0] d);
    idle(); wb_we = 1; wb_rd = AW'(rd); wb_data = d; tick();
  endtask

  task automatic test_reset();
    issue(1); issue(1); issue(2);
    idle(); iss_rs_en = 2'b11; iss_rs = {5'd2, 5'd1};
    rst = 0;
    #1;
    checks++; if (rs_ready !== 2'b00 || rs_data !== '0) begin errors++;
      $display("FAIL reset_hold_outputs: ready=%b data=%h required ready=00 data=0", rs_ready, rs_data); end
    checks++; if (stall_out !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL reset_hold_flags: stall=%b err=%b required 0 0", stall_out, err); end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1;
    #1;
    checks++; if (rs_ready !== 2'b11 || rs_data !== '0) begin errors++;
      $display("FAIL reset_release_reads: ready=%b data=%h required ready=11 data=0", rs_ready, rs_data); end
    checks++; if (stall_out !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL reset_release_flags: stall=%b err=%b required 0 0", stall_out, err); end
    tick();
  endtask

  task automatic test_fwd_basic();
    issue(5);
    idle(); iss_rs_en = 2'b01; iss_rs[4:0] = 5'd5;
    fwd_valid = 2'b01; fwd_ready = 2'b01; fwd_rd[4:0] = 5'd5; fwd_data[31:0] = 32'hDEAD;
    #1;
    checks++; if (rs_data[31:0] !== 32'hDEAD || rs_ready[0] !== 1'b1 || stall_out !== 1'b0) begin errors++;
      $display("FAIL fwd_basic: data=%h ready=%b stall=%b required DEAD 1 0", rs_data[31:0], rs_ready[0], stall_out); end
    tick();
    writeback(5, 32'hDEAD);
  endtask

  task automatic test_fwd_order();
    issue(7);
    idle(); iss_rs_en = 2'b10; iss_rs[9:5] = 5'd7;
    fwd_valid = 2'b11; fwd_ready = 2'b10; fwd_rd = {5'd7, 5'd7}; fwd_data = {32'h1111, 32'h0};
    #1;
    checks++; if (rs_ready[1] !== 1'b0 || stall_out !== 1'b1) begin errors++;
      $display("FAIL fwd_order_block: ready=%b stall=%b required 0 1", rs_ready[1], stall_out); end
    tick();
    fwd_valid = 2'b11; fwd_ready = 2'b11; fwd_rd = {5'd7, 5'd7}; fwd_data = {32'h1111, 32'h2222};
    iss_rs_en = 2'b10; iss_rs[9:5] = 5'd7;
    #1;
    checks++; if (rs_data[63:32] !== 32'h2222 || rs_ready[1] !== 1'b1 || stall_out !== 1'b0) begin errors++;
      $display("FAIL fwd_order_young: data=%h ready=%b stall=%b required 2222 1 0", rs_data[63:32], rs_ready[1], stall_out); end
    tick();
    writeback(7, 32'h2222);
  endtask

  task automatic test_saturation();
    issue(3); issue(3); issue(3);
    idle(); iss_valid = 1; iss_we = 1; iss_rd = 5'd3;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++;
      $display("FAIL sat_stall: stall=%b required 1", stall_out); end
    tick();
    writeback(3, 32'h33);
    idle(); iss_valid = 1; iss_we = 1; iss_rd = 5'd3;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++;
      $display("FAIL sat_release: stall=%b required 0", stall_out); end
    tick();
    idle(); iss_valid = 1; iss_we = 1; iss_rd = 5'd3;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++;
      $display("FAIL sat_refill: stall=%b required 1 (counter back at 3)", stall_out); end
    tick();
    writeback(3, 32'h33); writeback(3, 32'h33); writeback(3, 32'h33);
  endtask

  task automatic test_flush();
    issue(1); issue(1); issue(2);
    idle(); flush = 1; wb_we = 1; wb_rd = 5'd1; wb_data = 32'h1234;
    iss_valid = 1; iss_we = 1; iss_rd = 5'd4;
    tick();
    idle(); iss_rs_en = 2'b11; iss_rs = {5'd4, 5'd1};
    #1;
    checks++; if (rs_ready !== 2'b11 || rs_data[31:0] !== 32'h1234) begin errors++;
      $display("FAIL flush_x1_x4: ready=%b data0=%h required 11 1234", rs_ready, rs_data[31:0]); end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL flush_err: err=%b required 0", err); end
    tick();
    idle(); iss_rs_en = 2'b01; iss_rs[4:0] = 5'd2;
    #1;
    checks++; if (rs_ready[0] !== 1'b1 || rs_data[31:0] !== m_mem[2]) begin errors++;
      $display("FAIL flush_x2: ready=%b data=%h required 1 %h", rs_ready[0], rs_data[31:0], m_mem[2]); end
    tick();
  endtask

  task automatic test_err();
    writeback(9, 32'h99);
    idle(); iss_rs_en = 2'b01; iss_rs[4:0] = 5'd9;
    #1;
    checks++; if (err !== 1'b1 || rs_data[31:0] !== 32'h99 || rs_ready[0] !== 1'b1) begin errors++;
      $display("FAIL err_underflow: err=%b data=%h ready=%b required 1 99 1", err, rs_data[31:0], rs_ready[0]); end
    tick();
    idle(); iss_valid = 1; iss_we = 1; iss_rd = 5'd9; wb_we = 1; wb_rd = 5'd9; wb_data = 32'hAA;
    tick();
    idle(); iss_rs_en = 2'b01; iss_rs[4:0] = 5'd9;
    #1;
    checks++; if (err !== 1'b1 || rs_data[31:0] !== 32'hAA || rs_ready[0] !== 1'b1) begin errors++;
      $display("FAIL err_same_cycle: err=%b data=%h ready=%b required 1 AA 1", err, rs_data[31:0], rs_ready[0]); end
    tick();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] d;
    logic r;
    for (int c = 0; c < 400; c++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_we    = 1'($urandom_range(0, 3) != 0);
      iss_rd    = AW'($urandom_range(0, 7));
      iss_rs_en = 2'($urandom_range(0, 3));
      iss_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stall_in  = 1'($urandom_range(0, 7) == 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_ready = 2'($urandom_range(0, 3));
      fwd_rd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data  = {$urandom(), $urandom()};
      wb_we     = 1'($urandom_range(0, 1));
      wb_rd     = AW'($urandom_range(0, 7));
      wb_data   = $urandom();
      #1;
      for (int p = 0; p < NRD; p++) begin
        model_port(p, d, r);
        checks++;
        if (rs_ready[p] !== r || rs_data[p*XLEN +: XLEN] !== d) begin errors++;
          $display("FAIL rand_port%0d cyc%0d: ready=%b data=%h required %b %h", p, c, rs_ready[p], rs_data[p*XLEN +: XLEN], r, d); end
      end
      checks++;
      if (stall_out !== model_stall() || err !== m_err) begin errors++;
        $display("FAIL rand_flags cyc%0d: stall=%b err=%b required %b %b", c, stall_out, err, model_stall(), m_err); end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1;
    test_reset();
    test_fwd_basic();
    test_fwd_order();
    test_saturation();
    test_flush();
    test_err();
    test_random();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
